spread_enc: RTL and testbench
=============================

SPREAD_ENC -- requirements
Module: spread_enc

Interface
REQ-001 SHALL have parameter TEMPLATE, default 31'b0110101111000100110101111000100, the 31-chip spreading code; chip i = TEMPLATE[i].
REQ-002 SHALL have parameter PREAMBLE_LEN, default 4, the number of preamble symbols (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; synchronous and active-low.
REQ-005 SHALL have port data_in, input, 1, the data bit to spread.
REQ-006 SHALL have port data_valid, input, 1, meaning data_in is valid.
REQ-007 SHALL have port data_ready, output, 1, meaning a bit is accepted this cycle when data_valid is also high.
REQ-008 SHALL have port signal, output, 2, the chip stream to the despreader; both bits carry the same chip.
REQ-009 SHALL have port chip_valid, output, 1, meaning signal carries a chip.
REQ-010 SHALL have port sym_start, output, 1, a one-cycle pulse coincident with chip 0 of each symbol.
REQ-011 SHALL have port busy, output, 1, high when not in IDLE.

Function
REQ-012 States SHALL be IDLE, PREAMBLE and SPREAD.
REQ-013 A 5-bit chip counter SHALL count 0..30 and wrap to 0; a 4-bit symbol counter SHALL count preamble symbols.
REQ-014 Bit value 1 SHALL emit TEMPLATE[0], TEMPLATE[1], ... TEMPLATE[30] in that order; bit value 0 SHALL emit the bitwise inverse of the same sequence.
REQ-015 Each chip SHALL be presented on signal as {chip, chip} for exactly one clock.
REQ-016 All outputs except data_ready SHALL be registered.
REQ-017 data_ready SHALL be high in IDLE, and high in SPREAD only while the chip counter equals 30; it SHALL be low in PREAMBLE.
REQ-018 A bit is accepted on a clock edge where data_valid and data_ready are both high; the block SHALL latch data_in on that edge.
REQ-019 Accepting a bit in SPREAD at chip 30 SHALL start the next symbol at chip 0 on the following cycle, so back-to-back symbols have no gap.
REQ-020 Chip 0 of an accepted bit SHALL appear on signal in the cycle after the accepting edge, giving 1-cycle latency.
REQ-021 If chip 30 completes with no accept, the block SHALL return to IDLE, and the following cycle SHALL output signal=2'b00, chip_valid=0 and sym_start=0.
REQ-022 In IDLE, signal SHALL be 2'b00 and chip_valid SHALL be 0.
REQ-023 data_valid asserted while data_ready is low SHALL be ignored, with no state change; data_in SHALL be held by the source.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL set state to IDLE, both counters to 0, the latched bit to 0, signal to 2'b00, and chip_valid, sym_start and busy to 0.
REQ-025 Reset asserted mid-symbol or mid-preamble SHALL abort the burst immediately, with no partial chips after the reset edge.
REQ-026 data_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-027 With macro SPREAD_PREAMBLE_EN defined, an accept from IDLE SHALL enter PREAMBLE, emit PREAMBLE_LEN symbols of bit 1 with a sym_start pulse on each, then emit the latched bit in SPREAD.
REQ-028 With SPREAD_PREAMBLE_EN defined, continuation accepts in SPREAD SHALL not insert a preamble.
REQ-029 Without SPREAD_PREAMBLE_EN, the PREAMBLE state and the symbol counter SHALL be absent, and an accept from IDLE SHALL go directly to SPREAD.

Structure
REQ-030 Package spread_pkg SHALL hold CHIP_LEN=31, TEMPLATE_DEFAULT, PREAMBLE_LEN_DEFAULT and the state enum type.
REQ-031 Sub-module spread_chip_ctr SHALL implement the 0..30 chip counter with load-to-0, enable and a last-chip flag; the FSM and chip selection SHALL stay in spread_enc.

Verification
REQ-032 Test without the macro: reset, then one accept of bit 1 -> 31 cycles of signal equal to {TEMPLATE[i],TEMPLATE[i]} for i=0..30, sym_start only on i=0, then IDLE with 2'b00.
REQ-033 Test a single bit 0 -> inverted chips; signal fed into the existing despreader reads data_origin=0 at alignment, and a bit 1 reads data_origin=62.
REQ-034 Test data_valid held high with bits 1,0,1 -> 93 contiguous chips, data_ready high exactly at chip 30 of each symbol, no idle gap.
REQ-035 Test with SPREAD_PREAMBLE_EN and PREAMBLE_LEN=4, accept bit 0 -> 124 template chips, then 31 inverted chips, 5 sym_start pulses, and data_ready low for 154 cycles.
REQ-036 Test rst_n=0 at chip 15 -> the next cycle shows signal=2'b00, chip_valid=0 and busy=0, and a new accept restarts at chip 0.
REQ-037 Test data_valid pulsed at chip 10 -> ignored, and the symbol ends normally in IDLE.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared constants and state type for the DSSS spreading encoder.
// SPREAD_PREAMBLE_EN adds the PREAMBLE state.
package spread_pkg;

  localparam int          CHIP_LEN             = 31;
  localparam logic [30:0] TEMPLATE_DEFAULT     = 31'b0110101111000100110101111000100;
  localparam int          PREAMBLE_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPREAD = 2'd1
`ifdef SPREAD_PREAMBLE_EN
    ,
    PREAMBLE = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/spread_chip_ctr.sv
// Chip index counter for one spreading symbol: counts 0..CHIP_LEN-1 and wraps.
// load forces 0 and has priority over en; last flags the final chip.
module spread_chip_ctr
  import spread_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [4:0] cnt,
  output logic       last
);

  localparam logic [4:0] LAST_IDX = 5'(CHIP_LEN - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 5'd0;
    end else if (load) begin
      cnt <= 5'd0;
    end else if (en) begin
      cnt <= last ? 5'd0 : cnt + 5'd1;
    end
  end

endmodule

// File: rtl/spread_enc.sv
// DSSS spreading encoder: each accepted bit becomes 31 chips of TEMPLATE (inverted for 0).
// Macro SPREAD_PREAMBLE_EN prepends PREAMBLE_LEN all-ones symbols to each burst.
//
// Handshake: a bit is taken on a rising edge where data_valid && data_ready.
// data_ready is combinational (high in IDLE, or on chip 30 of a data symbol);
// the source must hold data_in stable while data_valid is high and not accepted.
module spread_enc
  import spread_pkg::*;
#(
  parameter logic [30:0] TEMPLATE     = TEMPLATE_DEFAULT,
  parameter int          PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] signal,
  output logic       chip_valid,
  output logic       sym_start,
  output logic       busy,
  output logic [1:0] dbg_state
);

  state_t     state, state_nx;
  logic       bit_q, bit_nx;
  logic [1:0] signal_nx;
  logic       chip_valid_nx, sym_start_nx, busy_nx;
  logic       ctr_load, ctr_en, chip_last;
  logic [4:0] chip_cnt;
  logic       accept;
`ifdef SPREAD_PREAMBLE_EN
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  logic [3:0] sym_cnt, sym_cnt_nx;
`endif

  // Chip value for index idx of a symbol carrying bit b.
  function automatic logic [1:0] chip_of(input logic [4:0] idx, input logic b);
    logic c;
    c = TEMPLATE[idx] ~^ b;
    return {c, c};
  endfunction

  spread_chip_ctr u_chip_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctr_load),
    .en    (ctr_en),
    .cnt   (chip_cnt),
    .last  (chip_last)
  );

  assign data_ready = rst_n && ((state == IDLE) || ((state == SPREAD) && chip_last));
  assign accept     = data_valid && data_ready;
  assign dbg_state  = state;

  // Outputs are computed for the chip that will be shown after the next edge.
  always_comb begin
    state_nx      = state;
    bit_nx        = bit_q;
    signal_nx     = 2'b00;
    chip_valid_nx = 1'b0;
    sym_start_nx  = 1'b0;
    ctr_load      = 1'b0;
    ctr_en        = 1'b0;
`ifdef SPREAD_PREAMBLE_EN
    sym_cnt_nx    = sym_cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          bit_nx        = data_in;
          ctr_load      = 1'b1;
          chip_valid_nx = 1'b1;
          sym_start_nx  = 1'b1;
`ifdef SPREAD_PREAMBLE_EN
          state_nx      = PREAMBLE;
          sym_cnt_nx    = 4'd0;
          signal_nx     = chip_of(5'd0, 1'b1);
`else
          state_nx      = SPREAD;
          signal_nx     = chip_of(5'd0, data_in);
`endif
        end
      end
      SPREAD: begin
        if (!chip_last) begin
          ctr_en        = 1'b1;
          chip_valid_nx = 1'b1;
          signal_nx     = chip_of(chip_cnt + 5'd1, bit_q);
        end else if (accept) begin
          bit_nx        = data_in;
          ctr_load      = 1'b1;
          chip_valid_nx = 1'b1;
          sym_start_nx  = 1'b1;
          signal_nx     = chip_of(5'd0, data_in);
        end else begin
          state_nx = IDLE;
          ctr_load = 1'b1;
        end
      end
`ifdef SPREAD_PREAMBLE_EN
      PREAMBLE: begin
        chip_valid_nx = 1'b1;
        if (!chip_last) begin
          ctr_en    = 1'b1;
          signal_nx = chip_of(chip_cnt + 5'd1, 1'b1);
        end else begin
          ctr_load     = 1'b1;
          sym_start_nx = 1'b1;
          if (sym_cnt == PRE_LAST) begin
            state_nx   = SPREAD;
            sym_cnt_nx = 4'd0;
            signal_nx  = chip_of(5'd0, bit_q);
          end else begin
            sym_cnt_nx = sym_cnt + 4'd1;
            signal_nx  = chip_of(5'd0, 1'b1);
          end
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        ctr_load = 1'b1;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_q      <= 1'b0;
      signal     <= 2'b00;
      chip_valid <= 1'b0;
      sym_start  <= 1'b0;
      busy       <= 1'b0;
`ifdef SPREAD_PREAMBLE_EN
      sym_cnt    <= 4'd0;
`endif
    end else begin
      state      <= state_nx;
      bit_q      <= bit_nx;
      signal     <= signal_nx;
      chip_valid <= chip_valid_nx;
      sym_start  <= sym_start_nx;
      busy       <= busy_nx;
`ifdef SPREAD_PREAMBLE_EN
      sym_cnt    <= sym_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_spread_enc.sv
// Bench for spread_enc: expected chips are queued at each accept and checked as they appear.
// Works with or without SPREAD_PREAMBLE_EN defined.
module tb_spread_enc;
  import spread_pkg::*;

  localparam logic [30:0] TPL  = TEMPLATE_DEFAULT;
  localparam int          PLEN = 4;
`ifdef SPREAD_PREAMBLE_EN
  localparam int PRE_CHIPS = PLEN * 31;
`else
  localparam int PRE_CHIPS = 0;
`endif

  logic       clk, rst_n, data_in, data_valid;
  logic       data_ready, chip_valid, sym_start, busy;
  logic [1:0] signal, dbg_state;

  spread_enc #(.TEMPLATE(TPL), .PREAMBLE_LEN(PLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .signal     (signal),
    .chip_valid (chip_valid),
    .sym_start  (sym_start),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  // entry: {preamble, idx[4:0], sym_start, signal[1:0]}
  logic [8:0] exp_q[$];
  logic       started   = 1'b0;
  int         run       = 0;
  int         last_run  = 0;
  int         acc       = 0;
  int         last_corr = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input logic pre, input int idx, input logic b);
    logic [30:0] t;
    logic        c;
    t = TPL;
    c = b ? t[idx] : ~t[idx];
    return {pre, 5'(idx), (idx == 0), c, c};
  endfunction

  task automatic push_symbol(input logic pre, input logic b);
    for (int i = 0; i < 31; i++) exp_q.push_back(mk(pre, i, b));
  endtask

  // driver: hold data_valid high across the burst, one bit per accept
  task automatic send_burst(input int n, input logic [2:0] bits);
    logic accepted;
    for (int k = 0; k < n; k++) begin
      data_in    = bits[k];
      data_valid = 1'b1;
      accepted   = 1'b0;
      for (int t = 0; t < 400 && !accepted; t++) begin
        @(negedge clk);
        if (data_ready) begin
          if (k == 0 && PRE_CHIPS > 0)
            for (int p = 0; p < PLEN; p++) push_symbol(1'b1, 1'b1);
          push_symbol(1'b0, bits[k]);
          accepted = 1'b1;
        end
        @(posedge clk);
        #1;
      end
      check("accept_timeout", accepted, 1);
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || chip_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t < 2000), 1);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [8:0]  e;
    logic [30:0] t;
    int          idx;
    t = TPL;
    if (!rst_n) begin
      run = 0;
    end else if (started) begin
      if (chip_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_chip", chip_valid, 0);
        end else begin
          e   = exp_q.pop_front();
          idx = int'(e[7:3]);
          check("signal", signal, e[1:0]);
          check("sym_start", sym_start, e[2]);
          check("data_ready", data_ready, (!e[8] && idx == 30));
          check("busy_active", busy, 1);
          if (e[2]) acc = 0;
          acc += int'(signal[1] == t[idx]) + int'(signal[0] == t[idx]);
          if (idx == 30) last_corr = acc;
        end
        run++;
      end else begin
        check("idle_signal", signal, 2'b00);
        check("idle_sym_start", sym_start, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", data_ready, 1);
        if (run > 0) begin
          last_run = run;
          run      = 0;
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_signal", signal, 2'b00);
    check("rst_chip_valid", chip_valid, 0);
    check("rst_sym_start", sym_start, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", data_ready, 1);
    started = 1'b1;
    @(posedge clk);
    #1;

    // single bit 1
    send_burst(1, 3'b001);
    wait_idle();
    check("run_bit1", last_run, PRE_CHIPS + 31);
    check("corr_bit1", last_corr, 62);

    // single bit 0
    send_burst(1, 3'b000);
    wait_idle();
    check("run_bit0", last_run, PRE_CHIPS + 31);
    check("corr_bit0", last_corr, 0);

    // back-to-back 1,0,1
    send_burst(3, 3'b101);
    wait_idle();
    check("run_b2b", last_run, PRE_CHIPS + 93);
    check("corr_b2b", last_corr, 62);

    // reset at chip 15 of the burst
    send_burst(1, 3'b001);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_signal", signal, 2'b00);
    check("abort_chip_valid", chip_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sym_start", sym_start, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_burst(1, 3'b000);
    wait_idle();
    check("run_restart", last_run, PRE_CHIPS + 31);
    check("corr_restart", last_corr, 0);

    // data_valid pulse while not ready is ignored
    send_burst(1, 3'b001);
    repeat (10) @(posedge clk);
    #1;
    data_in    = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    wait_idle();
    check("run_ignore", last_run, PRE_CHIPS + 31);
    check("corr_ignore", last_corr, 62);
    check("queue_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
